stream_mux_rr: RTL

//  Registered N:1 stream multiplexer with valid/ready handshake: next-generation datapath mux.

---
 rtl/stream_mux_rr_pkg.sv | 14 +
 rtl/stream_mux_rr_arbiter.sv | 43 ++++
 rtl/stream_mux_rr.sv | 92 +++++++++
 3 files changed

// File: rtl/stream_mux_rr_pkg.sv
// Shared definitions for the stream_mux_rr datapath multiplexer:
// mode encodings and the select-width helper used by every N-way block.
package stream_mux_rr_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: the request vector is doubled and
// rotated so the channel after 'last' lands at bit 0, then priority-encoded.
module rr_arbiter
  import stream_mux_rr_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = sel_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] last,
  input  logic          en,
  output logic [N-1:0]  gnt_onehot,
  output logic [SW-1:0] gnt_idx,
  output logic          gnt_any
);

  logic [2*N-1:0] rot;
  int             start;
  int             idx;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    start   = (int'(last) >= N - 1) ? 0 : int'(last) + 1;
    rot     = {req, req} >> start;
    for (int k = 0; k < N; k++) begin
      if (!gnt_any && en && rot[k]) begin
        idx     = (start + k >= N) ? start + k - N : start + k;
        gnt_any = 1'b1;
        gnt_idx = SW'(idx);
      end
    end
  end

  always_comb begin
    gnt_onehot = '0;
    for (int j = 0; j < N; j++) begin
      gnt_onehot[j] = gnt_any && (gnt_idx == SW'(j));
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// Registered N:1 valid/ready stream multiplexer with fixed-select and
// round-robin modes; one word of output buffering, no bubble on drain+refill.
module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = sel_width(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           E,
  input  logic           mode,
  input  logic [SW-1:0]  S,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  input  logic           out_ready
);

  logic          load;
  logic          xfer;
  logic          rr_mode;
  logic [SW-1:0] last;
  logic [N-1:0]  arb_oh;
  logic [SW-1:0] arb_idx;
  logic          arb_any;
  logic [N-1:0]  fix_oh;
  logic          fix_any;
  logic [N-1:0]  gnt_oh;
  logic [SW-1:0] gnt_idx;
  logic          gnt_any;
  logic [W-1:0]  gnt_data;

  assign rr_mode = (mode == MODE_RR);
  assign load    = !out_valid || out_ready;

  rr_arbiter #(.N(N), .SW(SW)) u_arb (
    .req        (in_valid),
    .last       (last),
    .en         (rr_mode),
    .gnt_onehot (arb_oh),
    .gnt_idx    (arb_idx),
    .gnt_any    (arb_any)
  );

  // Out-of-range selects match no channel, so they simply yield no grant.
  always_comb begin
    fix_oh = '0;
    for (int i = 0; i < N; i++) begin
      fix_oh[i] = (S == SW'(i)) && in_valid[i];
    end
    fix_any = |fix_oh;
  end

  always_comb begin
    gnt_oh  = rr_mode ? arb_oh  : fix_oh;
    gnt_idx = rr_mode ? arb_idx : S;
    gnt_any = rr_mode ? arb_any : fix_any;
  end

  assign in_ready = (E && load) ? gnt_oh : '0;
  assign xfer     = E && load && gnt_any;

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_oh[i]) gnt_data = in_data[i*W +: W];
    end
  end

  // The pointer only advances on round-robin transfers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      last      <= SW'(N - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_sel   <= gnt_idx;
      if (rr_mode) last <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
